type_buffer: RTL and testbench

- Upstream stage of the VGA display block. It consumes decoded keyboard events and maintains the line the player is currently typing.
- Produces the packed typed-text array (`type`), the matched-prefix count (`correct`) and the typed length (`tot`) that the display renders.
- Also tracks word completion, total keystrokes and error keystrokes, which feed the WPM/accuracy statistics stage.

---
 rtl/type_buffer.sv | 167 ++++++++++++++++
 tb/tb_type_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/type_buffer.sv
// Typed-line buffer for the typing race: edits the current line from decoded key events and
// tracks matched prefix, word commits and keystroke/error counts. Optional: STRICT_SPACE_EN.
// The typed-text output is named type_text because `type` is a reserved word.
module type_buffer #(
    parameter int unsigned MAX_LEN     = 25,
    parameter int unsigned TGT_LEN     = 15,
    parameter int unsigned WORDS_TOTAL = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    input  logic [4:0]             key_code,
    input  logic                   key_bs,
    input  logic                   key_space,
    input  logic [5*TGT_LEN-1:0]   target_word,
    input  logic [4:0]             target_len,
    output logic [5*MAX_LEN-1:0]   type_text,
    output logic [4:0]             correct,
    output logic [4:0]             tot,
    output logic                   word_done,
    output logic [2:0]             word_idx,
    output logic                   running,
    output logic                   finished,
    output logic [15:0]            keystrokes,
    output logic [15:0]            errors
);

    typedef enum logic [1:0] {StIdle, StType, StDone} state_e;

    state_e                  state_q, state_d;
    logic [MAX_LEN-1:0][4:0] buf_q, buf_d;
    logic [4:0]              tot_q, tot_d, correct_q, correct_d;
    logic [15:0]             ks_q, ks_d, err_q, err_d;
    logic [2:0]              widx_q, widx_d;
    logic                    done_q, done_d;
    logic                    commit, exact, active;
    logic [4:0]              cur_match, tgt_char;

    // Length of the leading run of buffer chars that equal the target, capped by both lengths.
    function automatic logic [4:0] prefix_len(input logic [MAX_LEN-1:0][4:0] b,
                                              input logic [4:0] n,
                                              input logic [5*TGT_LEN-1:0] t,
                                              input logic [4:0] tl);
        logic [4:0] cnt;
        logic       stop;
        cnt  = 5'd0;
        stop = 1'b0;
        for (int k = 0; k < int'(TGT_LEN); k++) begin
            if (!stop && (5'(k) < n) && (5'(k) < tl) && (b[k] == t[5*k +: 5])) begin
                cnt = cnt + 5'd1;
            end else begin
                stop = 1'b1;
            end
        end
        return cnt;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        buf_d     = buf_q;
        tot_d     = tot_q;
        ks_d      = ks_q;
        err_d     = err_q;
        widx_d    = widx_q;
        done_d    = 1'b0;
        commit    = 1'b0;
        correct_d = correct_q;
        cur_match = prefix_len(buf_q, tot_q, target_word, target_len);
        exact     = (tot_q == target_len) && (cur_match == target_len);
        active    = key_valid && (state_q != StDone);
        tgt_char  = 5'd0;
        for (int k = 0; k < int'(TGT_LEN); k++) begin
            if (5'(k) == tot_q) tgt_char = target_word[5*k +: 5];
        end

        if (active) begin
            if (key_bs) begin
                if (state_q == StType && tot_q != 5'd0) begin
                    buf_d[tot_q - 5'd1] = 5'd0;
                    tot_d               = tot_q - 5'd1;
                end
            end else if (key_space) begin
                if (state_q == StType) begin
`ifdef STRICT_SPACE_EN
                    if (exact) commit = 1'b1;
                    else       err_d  = sat_add(err_q, 16'd1);
`else
                    // A premature commit charges every unmatched target position as an error.
                    if (tot_q != 5'd0) begin
                        commit = 1'b1;
                        err_d  = sat_add(err_q, {11'd0, target_len - cur_match});
                    end
`endif
                end
            end else if (key_code != 5'd0) begin
                if (tot_q < 5'(MAX_LEN)) begin
                    buf_d[tot_q] = key_code;
                    tot_d        = tot_q + 5'd1;
                    ks_d         = sat_add(ks_q, 16'd1);
                    if (tot_q >= target_len || key_code != tgt_char) err_d = sat_add(err_q, 16'd1);
                end
            end

            if (commit) begin
                buf_d  = '0;
                tot_d  = 5'd0;
                done_d = 1'b1;
                widx_d = widx_q + 3'd1;
            end
            correct_d = prefix_len(buf_d, tot_d, target_word, target_len);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (key_valid && !key_bs && !key_space && key_code != 5'd0) state_d = StType;
            StType:  if (commit && widx_d == 3'(WORDS_TOTAL)) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        running  = (state_q == StType);
        finished = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q     <= '0;
            tot_q     <= 5'd0;
            correct_q <= 5'd0;
            ks_q      <= 16'd0;
            err_q     <= 16'd0;
            widx_q    <= 3'd0;
            done_q    <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            tot_q     <= tot_d;
            correct_q <= correct_d;
            ks_q      <= ks_d;
            err_q     <= err_d;
            widx_q    <= widx_d;
            done_q    <= done_d;
        end
    end

    assign type_text  = buf_q;
    assign tot        = tot_q;
    assign correct    = correct_q;
    assign keystrokes = ks_q;
    assign errors     = err_q;
    assign word_idx   = widx_q;
    assign word_done  = done_q;

endmodule

// File: tb/tb_type_buffer.sv
// Randomized bench for type_buffer against a queue-based model of the typing rules.
// Build with +define+STRICT_SPACE_EN to check the strict-space variant.
module tb_type_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [4:0]   key_code = 5'd0;
    logic         key_bs = 1'b0;
    logic         key_space = 1'b0;
    logic [74:0]  target_word = '0;
    logic [4:0]   target_len = 5'd1;
    logic [124:0] type_text;
    logic [4:0]   correct, tot;
    logic         word_done, running, finished;
    logic [2:0]   word_idx;
    logic [15:0]  keystrokes, errors;

    type_buffer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_bs(key_bs),
        .key_space(key_space), .target_word(target_word), .target_len(target_len),
        .type_text(type_text), .correct(correct), .tot(tot), .word_done(word_done),
        .word_idx(word_idx), .running(running), .finished(finished),
        .keystrokes(keystrokes), .errors(errors)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the typed line is a queue of letter codes.
    int m_buf[$];
    int tgt[15];
    int tlen;
    int m_state;  // 0 idle, 1 typing, 2 done
    int m_ks, m_err, m_widx, m_correct;
    bit m_done;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_prefix();
        int n = 0;
        for (int k = 0; k < m_buf.size() && k < tlen; k++) begin
            if (m_buf[k] != tgt[k]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [124:0] m_pack();
        logic [124:0] v = '0;
        for (int k = 0; k < m_buf.size(); k++) v[5*k +: 5] = 5'(m_buf[k]);
        return v;
    endfunction

    function automatic void m_reset();
        m_buf.delete();
        m_state = 0; m_ks = 0; m_err = 0; m_widx = 0; m_correct = 0; m_done = 0;
    endfunction

    function automatic void m_step(input bit v, input int code, input bit bs, input bit sp);
        int pos, match;
        m_done = 0;
        if (!v || m_state == 2) return;
        if (bs) begin
            if (m_state == 1 && m_buf.size() > 0) void'(m_buf.pop_back());
        end else if (sp) begin
            if (m_state == 1) begin
                bit do_commit;
                match = m_prefix();
`ifdef STRICT_SPACE_EN
                do_commit = (m_buf.size() == tlen) && (match == tlen);
                if (!do_commit) m_err = (m_err + 1 > 65535) ? 65535 : m_err + 1;
`else
                do_commit = m_buf.size() > 0;
                if (do_commit) m_err = (m_err + tlen - match > 65535) ? 65535 : m_err + tlen - match;
`endif
                if (do_commit) begin
                    m_buf.delete();
                    m_done = 1;
                    m_widx++;
                    if (m_widx == 5) m_state = 2;
                end
            end
        end else if (code != 0) begin
            if (m_state == 0) m_state = 1;
            if (m_buf.size() < 25) begin
                pos = m_buf.size();
                m_buf.push_back(code);
                m_ks = (m_ks + 1 > 65535) ? 65535 : m_ks + 1;
                if (pos >= tlen || code != tgt[pos]) m_err = (m_err + 1 > 65535) ? 65535 : m_err + 1;
            end
        end
        m_correct = m_prefix();
    endfunction

    task automatic check_all();
        check("type", type_text, m_pack());
        check("tot", tot, m_buf.size());
        check("correct", correct, m_correct);
        check("word_done", word_done, m_done);
        check("word_idx", word_idx, m_widx);
        check("running", running, m_state == 1);
        check("finished", finished, m_state == 2);
        check("keystrokes", keystrokes, m_ks);
        check("errors", errors, m_err);
    endtask

    task automatic apply(input bit v, input int code, input bit bs, input bit sp);
        @(negedge clk);
        key_valid = v; key_code = 5'(code); key_bs = bs; key_space = sp;
        m_step(v, code, bs, sp);
        @(posedge clk);
        #1;
        check_all();
        key_valid = 1'b0; key_code = 5'd0; key_bs = 1'b0; key_space = 1'b0;
    endtask

    task automatic set_target(input int len, input bit rnd, input int c0, input int c1,
                              input int c2);
        tlen = len;
        for (int k = 0; k < 15; k++) tgt[k] = (k < len) ? (rnd ? int'($urandom_range(1, 26)) : 0) : 0;
        if (!rnd) begin tgt[0] = c0; tgt[1] = c1; tgt[2] = c2; end
        target_len = 5'(len);
        for (int k = 0; k < 15; k++) target_word[5*k +: 5] = 5'(tgt[k]);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        m_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic type_target();
        for (int k = 0; k < tlen; k++) apply(1, tgt[k], 0, 0);
    endtask

    initial begin
        int r, code;
        m_reset();
        set_target(3, 0, 3, 1, 20);
        do_reset();

        // CAT against CAT
        apply(1, 3, 0, 0); apply(1, 1, 0, 0); apply(1, 20, 0, 0);
        check("cat_tot", tot, 3);
        check("cat_correct", correct, 3);
        check("cat_type", type_text[14:0], {5'd20, 5'd1, 5'd3});
        check("cat_running", running, 1);

        // CO then backspace
        do_reset();
        apply(1, 3, 0, 0); apply(1, 15, 0, 0);
        check("co_errors", errors, 1);
        apply(1, 0, 1, 0);
        check("bs_tot", tot, 1);
        check("bs_errors", errors, 1);

        // Five committed words, then keys after DONE
        do_reset();
        for (int w = 0; w < 5; w++) begin
            set_target($urandom_range(1, 15), 1, 0, 0, 0);
            type_target();
            apply(1, 0, 0, 1);
            apply(0, 0, 0, 0);
        end
        check("race_finished", finished, 1);
        for (int i = 0; i < 6; i++) apply(1, $urandom_range(0, 26), i[0], i[1]);

        // Overflow past capacity, then backspace beating a same-cycle letter
        do_reset();
        set_target(15, 1, 0, 0, 0);
        for (int i = 0; i < 26; i++) apply(1, $urandom_range(1, 26), 0, 0);
        check("full_ks", keystrokes, 25);
        apply(1, 5, 1, 0);
        check("bs_prio_tot", tot, 24);

        // Premature space
        do_reset();
        set_target(3, 0, 3, 1, 20);
        apply(1, 3, 0, 0); apply(1, 1, 0, 0); apply(1, 0, 0, 1);
        check("ca_space_err", errors, 1);

        // Asynchronous reset mid-word
        do_reset();
        for (int i = 0; i < 4; i++) apply(1, $urandom_range(1, 26), 0, 0);
        #2 rst = 1'b0;
        m_reset();
        #1 check_all();
        check("async_tot", tot, 0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            do_reset();
            set_target($urandom_range(1, 15), 1, 0, 0, 0);
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 99);
                code = $urandom_range(0, 26);
                if (r < 45) begin
                    code = (m_buf.size() < tlen) ? tgt[m_buf.size()] : $urandom_range(1, 26);
                    apply(1, code, 0, 0);
                end else if (r < 60) apply(1, $urandom_range(1, 26), 0, 0);
                else if (r < 72)     apply(1, code, 1, 0);
                else if (r < 85)     apply(1, code, 0, 1);
                else if (r < 92)     apply(1, code, 1, 1);
                else                 apply(0, code, $urandom_range(0, 1), $urandom_range(0, 1));
                if (m_done) set_target($urandom_range(1, 15), 1, 0, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
